cpu_sram_responder: RTL
=======================

// Module: cpu_sram_responder
// PURPOSE
//   Memory-side responder for the CPU byte bus (address/i_data/o_data/we). It serves
//   byte reads and writes from a 16-bit external asynchronous SRAM on the DE0 board.
//   It adds a 'ready' handshake so the CPU can stall while an SRAM cycle is in flight.
//   Writes at or above ROM_BASE are dropped when ROM_PROTECT=1 (BIOS shadow).
// PARAMETERS
//   RD_WAIT      2         cycles the OE strobe is held before read data is sampled (>=1)
//   WR_WAIT      2         cycles the WE strobe is held low per write (>=1)
//   ROM_BASE     20'hF0000 first write-protected byte address
//   ROM_PROTECT  1         1 = drop CPU writes at address >= ROM_BASE
// PORTS
//   clock      in    1   system clock, 25 MHz
//   reset_n    in    1   asynchronous active-low reset
//   address    in   20   CPU byte address
//   w_data     in    8   CPU write data (CPU o_data)
//   we         in    1   CPU write request
//   r_data     out   8   read data to CPU (CPU i_data), registered
//   ready      out   1   1 = r_data valid / write done for current {address,we,w_data}
//   sram_addr  out  19   SRAM word address = address[19:1]
//   sram_dq    inout 16  SRAM data; byte 0 on [7:0], byte 1 on [15:8]
//   sram_ce_n  out   1   chip enable, active low
//   sram_oe_n  out   1   output enable, active low
//   sram_we_n  out   1   write enable, active low
//   sram_lb_n  out   1   low-byte enable, active low
//   sram_ub_n  out   1   high-byte enable, active low
// BEHAVIOUR
//   Reset values: r_data=0, all sram_*_n=1, sram_addr=0, sram_dq=Z, state=IDLE.
//     Tag valid=0, so ready=0.
//   Tag: {valid, t_addr, t_we, t_wdata} holds the last completed request.
//   match = valid & address==t_addr & we==t_we & (!we | w_data==t_wdata).
//   ready = (state==IDLE) & match. This is combinational, so ready drops in the
//     same cycle the request changes.
//   FSM: IDLE, READ, WRITE, WHOLD, DONE.
//   IDLE: if !match, latch address/we/w_data into p_* regs.
//     Write to a protected address (p_addr >= ROM_BASE, ROM_PROTECT=1): go to DONE.
//     Other write: go to WRITE. Read: go to READ.
//   READ (RD_WAIT cycles): ce_n=0, oe_n=0, lb_n=ub_n=0, dq=Z.
//     On the last cycle, r_data <= p_addr[0] ? dq[15:8] : dq[7:0].
//     Tag <= {1,p_*}, then go to IDLE.
//   WRITE (WR_WAIT cycles): ce_n=0, we_n=0, oe_n=1, dq={p_wdata,p_wdata}.
//     lb_n=p_addr[0], ub_n=~p_addr[0].
//   WHOLD (1 cycle): we_n=1; ce_n, dq and byte enables unchanged (data hold).
//     r_data <= p_wdata; tag <= {1,p_*}; go to IDLE.
//   DONE (1 cycle): no SRAM strobes; r_data unchanged; tag <= {1,p_*}; go to IDLE.
//   Latency, counted from request change at edge N (ready low from N):
//     read: ready high after RD_WAIT+1 cycles.
//     write: WR_WAIT+2 cycles.
//     protected write: 2 cycles.
//   Repeat of a matching request: ready stays 1 and no SRAM cycle is issued.
//     A held write is performed exactly once.
//   Request change mid-access: the in-flight access completes with the p_* values.
//     IDLE then sees a mismatch and starts a new access; ready stays 0 throughout.
//   sram_addr is driven from p_addr[19:1] during accesses and holds its value in IDLE.
//   Address wrap: 20'hFFFFF maps to word 19'h7FFFF, high byte. No other wrap logic.
//   Reset mid-access: strobes go to 1 and dq goes to Z immediately (async); the access is lost.
//   All SRAM strobes are registered outputs; no glitches on *_n.
// TESTING
//   1 Reset, then read address 20'h00001 with SRAM word 0=16'hA55A, RD_WAIT=2
//     -> ready 0 for 3 cycles, then r_data=8'hA5, ready=1.
//   2 Write 8'h3C to 20'h12344 -> we_n low 2 cycles, lb_n=0, ub_n=1, dq=16'h3C3C,
//     sram_addr=19'h091A2; ready after 4 cycles; readback r_data=8'h3C.
//   3 Hold we=1 on the same address/data for 20 cycles -> exactly one WE pulse; ready stays 1.
//   4 ROM_PROTECT=1, write 8'hFF to 20'hF0010 -> no WE pulse, ready after 2 cycles,
//     SRAM content unchanged; same write to 20'hEFFFF is performed.
//   5 Change address during READ cycle 1 -> first read completes, a second read follows,
//     final r_data matches the new address, ready low throughout.
//   6 Assert reset_n=0 during WRITE -> we_n=1, ce_n=1, dq=Z in the same cycle;
//     after release ready=0 until a new access completes.

Source files
------------

// File: rtl/cpu_sram_responder.sv
// CPU byte-bus responder over a 16-bit async SRAM. Ready after RD_WAIT+1 (read), WR_WAIT+2 (write), 2 (ROM-protected write).
// Backpressure: ready is low while the request differs from the last completed one; the CPU must hold its request until ready.
module cpu_sram_responder #(
    parameter int          RD_WAIT     = 2,
    parameter int          WR_WAIT     = 2,
    parameter logic [19:0] ROM_BASE    = 20'hF0000,
    parameter bit          ROM_PROTECT = 1'b1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [19:0] address,
    input  logic [7:0]  w_data,
    input  logic        we,
    output logic [7:0]  r_data,
    output logic        ready,
    output logic [18:0] sram_addr,
    inout  wire  [15:0] sram_dq,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_lb_n,
    output logic        sram_ub_n
);

    typedef enum logic [2:0] {IDLE, READ, WRITE, WHOLD, DONE} state_t;

    state_t      state;
    logic [7:0]  cnt;
    logic [19:0] p_addr, t_addr;
    logic        p_we, t_we, t_valid;
    logic [7:0]  p_wdata, t_wdata;
    logic        dq_oe;
    logic [15:0] dq_out;
    logic        match, prot;

    // Tag holds the last completed request; a repeat of it is answered without touching the SRAM.
    assign match   = t_valid && (address == t_addr) && (we == t_we) && (!we || (w_data == t_wdata));
    assign ready   = (state == IDLE) && match;
    assign prot    = ROM_PROTECT && (address >= ROM_BASE);
    assign sram_dq = dq_oe ? dq_out : 16'hzzzz;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            p_addr    <= '0;
            p_we      <= 1'b0;
            p_wdata   <= '0;
            t_valid   <= 1'b0;
            t_addr    <= '0;
            t_we      <= 1'b0;
            t_wdata   <= '0;
            r_data    <= '0;
            sram_addr <= '0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_lb_n <= 1'b1;
            sram_ub_n <= 1'b1;
            dq_oe     <= 1'b0;
            dq_out    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (!match) begin
                        p_addr  <= address;
                        p_we    <= we;
                        p_wdata <= w_data;
                        cnt     <= '0;
                        if (we && prot) begin
                            state <= DONE;
                        end else begin
                            sram_addr <= address[19:1];
                            sram_ce_n <= 1'b0;
                            if (we) begin
                                state     <= WRITE;
                                sram_we_n <= 1'b0;
                                dq_oe     <= 1'b1;
                                dq_out    <= {w_data, w_data};
                                sram_lb_n <= address[0];
                                sram_ub_n <= ~address[0];
                            end else begin
                                state     <= READ;
                                sram_oe_n <= 1'b0;
                                sram_lb_n <= 1'b0;
                                sram_ub_n <= 1'b0;
                            end
                        end
                    end
                end
                READ: begin
                    if (cnt == 8'(RD_WAIT - 1)) begin
                        r_data    <= p_addr[0] ? sram_dq[15:8] : sram_dq[7:0];
                        t_valid   <= 1'b1;
                        t_addr    <= p_addr;
                        t_we      <= p_we;
                        t_wdata   <= p_wdata;
                        sram_ce_n <= 1'b1;
                        sram_oe_n <= 1'b1;
                        sram_lb_n <= 1'b1;
                        sram_ub_n <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                WRITE: begin
                    if (cnt == 8'(WR_WAIT - 1)) begin
                        sram_we_n <= 1'b1;
                        state     <= WHOLD;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                // Data and byte enables stay one cycle past the WE rising edge for hold time.
                WHOLD: begin
                    r_data    <= p_wdata;
                    t_valid   <= 1'b1;
                    t_addr    <= p_addr;
                    t_we      <= p_we;
                    t_wdata   <= p_wdata;
                    sram_ce_n <= 1'b1;
                    sram_lb_n <= 1'b1;
                    sram_ub_n <= 1'b1;
                    dq_oe     <= 1'b0;
                    state     <= IDLE;
                end
                DONE: begin
                    t_valid <= 1'b1;
                    t_addr  <= p_addr;
                    t_we    <= p_we;
                    t_wdata <= p_wdata;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
